mem_sram_stage: RTL and testbench

Memory stage of the five-stage ARM pipeline, directly downstream of the execute stage. It consumes the execute stage's memory controls, ALU result (used as the address), Rm value (store data), WB enable and destination. It performs 32-bit loads and stores on an external 16-bit asynchronous SRAM as two half-word phases, stalling the pipeline through `ready`. It also carries the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_sram_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_sram_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sram_stage.sv
// Memory stage of the pipeline: 32-bit loads/stores on a 16-bit asynchronous SRAM
// as two half-word phases, plus the MEM/WB register that feeds write-back.
//
// state | meaning
// IDLE  | no access in flight; ready follows ~req
// LOW   | low half-word phase at {idx,0}, cnt counts 0..WAIT
// HIGH  | high half-word phase at {idx,1}, cnt counts 0..WAIT
// DONE  | access complete; upstream advances this cycle
module mem_sram_stage #(
  parameter int unsigned BASE_ADDR = 1024,
  parameter int unsigned WAIT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        WB_EN,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] Val_Rm,
  input  logic [3:0]  Dest,
  output logic        ready,
  output logic        WB_EN_out,
  output logic        MEM_R_EN_out,
  output logic [31:0] ALU_Res_out,
  output logic [31:0] MEM_Result,
  output logic [3:0]  Dest_out,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  localparam logic [31:0] BASE_C  = 32'(BASE_ADDR);
  localparam logic [3:0]  WAIT_C  = 4'(WAIT);
  localparam logic [3:0]  WAIT_M1 = 4'(WAIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rd_q, rd_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] dq_q, dq_d;
  logic        oe_q, oe_d;
  logic        we_n_q, we_n_d;
  logic        wb_en_q, wb_en_d;
  logic        mem_r_q, mem_r_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] memres_q, memres_d;
  logic [3:0]  dest_q, dest_d;

  logic        req;
  logic        is_wr;
  logic [16:0] idx;
  logic        ready_c;

  assign req     = MEM_R_EN | MEM_W_EN;
  assign is_wr   = MEM_W_EN;
  // Offset wraps modulo 2^32; byte-lane bits are dropped.
  assign idx     = 17'((ALU_Res - BASE_C) >> 2);
  assign ready_c = ((state_q == S_IDLE) && !req) || (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    dq_d    = dq_q;
    oe_d    = oe_q;
    we_n_d  = we_n_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_LOW;
          cnt_d   = 4'd0;
          addr_d  = {idx, 1'b0};
          if (is_wr) begin
            dq_d   = Val_Rm[15:0];
            oe_d   = 1'b1;
            we_n_d = 1'b0;
          end
        end
      end
      S_LOW, S_HIGH: begin
        if (cnt_q == WAIT_C) begin
          cnt_d = 4'd0;
          if (!is_wr) begin
            if (state_q == S_LOW) rd_d[15:0]  = SRAM_DQ_in;
            else                  rd_d[31:16] = SRAM_DQ_in;
          end
          if (state_q == S_LOW) begin
            state_d = S_HIGH;
            addr_d  = {idx, 1'b1};
            if (is_wr) begin
              dq_d   = Val_Rm[31:16];
              we_n_d = 1'b0;
            end
          end else begin
            state_d = S_DONE;
            oe_d    = 1'b0;
            we_n_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          // Strobe rises one cycle before the address moves.
          if (cnt_q == WAIT_M1) we_n_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wb_en_d  = 1'b0;
    mem_r_d  = mem_r_q;
    alu_d    = alu_q;
    memres_d = memres_q;
    dest_d   = dest_q;
    if (ready_c) begin
      wb_en_d = WB_EN;
      mem_r_d = MEM_R_EN;
      alu_d   = ALU_Res;
      dest_d  = Dest;
      if (state_q == S_DONE) memres_d = rd_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      rd_q     <= 32'd0;
      addr_q   <= 18'd0;
      dq_q     <= 16'd0;
      oe_q     <= 1'b0;
      we_n_q   <= 1'b1;
      wb_en_q  <= 1'b0;
      mem_r_q  <= 1'b0;
      alu_q    <= 32'd0;
      memres_q <= 32'd0;
      dest_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      dq_q     <= dq_d;
      oe_q     <= oe_d;
      we_n_q   <= we_n_d;
      wb_en_q  <= wb_en_d;
      mem_r_q  <= mem_r_d;
      alu_q    <= alu_d;
      memres_q <= memres_d;
      dest_q   <= dest_d;
    end
  end

  assign ready        = ready_c;
  assign WB_EN_out    = wb_en_q;
  assign MEM_R_EN_out = mem_r_q;
  assign ALU_Res_out  = alu_q;
  assign MEM_Result   = memres_q;
  assign Dest_out     = dest_q;
  assign SRAM_ADDR    = addr_q;
  assign SRAM_DQ_out  = dq_q;
  assign SRAM_DQ_oe   = oe_q;
  assign SRAM_WE_N    = we_n_q;

endmodule

// File: tb/tb_mem_sram_stage.sv
// Bench for mem_sram_stage: two instances (WAIT=1 and WAIT=3), each with its own
// SRAM model, driven by random instructions and checked through a retire scoreboard.
module tb_mem_sram_stage;

  localparam logic [31:0] BASE = 32'd1024;
  localparam int W0 = 1;
  localparam int W1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n, mem_r, mem_w, wb_en, ready, wb_en_out, mem_r_out, oe, we_n;
  logic [1:0][31:0] alu_res, val_rm, alu_out, mem_res;
  logic [1:0][3:0]  dest, dest_out;
  logic [1:0][17:0] s_addr;
  logic [1:0][15:0] dq_out, dq_in;

  mem_sram_stage #(.BASE_ADDR(1024), .WAIT(W0)) u_w1 (
    .clk(clk), .rst(rst_n[0]), .MEM_R_EN(mem_r[0]), .MEM_W_EN(mem_w[0]), .WB_EN(wb_en[0]),
    .ALU_Res(alu_res[0]), .Val_Rm(val_rm[0]), .Dest(dest[0]), .ready(ready[0]),
    .WB_EN_out(wb_en_out[0]), .MEM_R_EN_out(mem_r_out[0]), .ALU_Res_out(alu_out[0]),
    .MEM_Result(mem_res[0]), .Dest_out(dest_out[0]), .SRAM_ADDR(s_addr[0]),
    .SRAM_DQ_out(dq_out[0]), .SRAM_DQ_oe(oe[0]), .SRAM_DQ_in(dq_in[0]), .SRAM_WE_N(we_n[0]));

  mem_sram_stage #(.BASE_ADDR(1024), .WAIT(W1)) u_w3 (
    .clk(clk), .rst(rst_n[1]), .MEM_R_EN(mem_r[1]), .MEM_W_EN(mem_w[1]), .WB_EN(wb_en[1]),
    .ALU_Res(alu_res[1]), .Val_Rm(val_rm[1]), .Dest(dest[1]), .ready(ready[1]),
    .WB_EN_out(wb_en_out[1]), .MEM_R_EN_out(mem_r_out[1]), .ALU_Res_out(alu_out[1]),
    .MEM_Result(mem_res[1]), .Dest_out(dest_out[1]), .SRAM_ADDR(s_addr[1]),
    .SRAM_DQ_out(dq_out[1]), .SRAM_DQ_oe(oe[1]), .SRAM_DQ_in(dq_in[1]), .SRAM_WE_N(we_n[1]));

  typedef struct packed {
    logic        wb;
    logic        mr;
    logic [31:0] alu;
    logic [3:0]  dst;
    logic [31:0] res;
  } wb_t;

  wb_t         exp_q [2][$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          instr_id [2];
  int          we_low [2];
  logic [31:0] rd_m [2];
  logic [31:0] memres_m [2];
  logic [31:0] wmem [int];
  logic [15:0] sram [int];

  function automatic int wait_of(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  function automatic logic [15:0] init16(input logic [17:0] a);
    return 16'(32'(a) * 32'd40503 + 32'd17);
  endfunction

  function automatic logic [15:0] sram_rd(input int d, input logic [17:0] a);
    int k = d * (1 << 18) + int'(a);
    if (sram.exists(k)) return sram[k];
    return init16(a);
  endfunction

  function automatic logic [31:0] ref_rd(input int d, input logic [16:0] idx);
    int k = d * (1 << 17) + int'(idx);
    if (wmem.exists(k)) return wmem[k];
    return {init16({idx, 1'b1}), init16({idx, 1'b0})};
  endfunction

  function automatic void chk(input int d, input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL dut%0d %s: got 0x%08h, expected 0x%08h", d, nm, act, exp);
    end
  endfunction

  // SRAM model: writes while the strobe is low; read data is only valid once the
  // address has been stable for WAIT cycles, otherwise the bus shows garbage.
  int          a_age [2];
  logic [17:0] last_a [2];
  initial begin
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++)
        if (rst_n[d] === 1'b1 && we_n[d] === 1'b0)
          sram[d * (1 << 18) + int'(s_addr[d])] = dq_out[d];
    end
  end

  initial begin
    dq_in = '0;
    for (int d = 0; d < 2; d++) begin a_age[d] = 0; last_a[d] = 18'd0; we_low[d] = 0; end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic [15:0] v;
        if (s_addr[d] !== last_a[d]) a_age[d] = 0;
        else a_age[d]++;
        last_a[d] = s_addr[d];
        v = sram_rd(d, s_addr[d]);
        dq_in[d] = (a_age[d] >= wait_of(d)) ? v : ~v;
        if (we_n[d] === 1'b0) we_low[d]++;
      end
    end
  end

  // Monitor: checks ready against the stall length and retires WB outputs.
  int   age [2];
  int   last_id [2];
  logic prev_rdy [2];
  initial begin
    for (int d = 0; d < 2; d++) begin age[d] = 0; last_id[d] = -1; prev_rdy[d] = 1'b0; end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst_n[d] !== 1'b1) begin
          prev_rdy[d] = 1'b0;
          last_id[d]  = -1;
        end else begin
          logic exp_r;
          wb_t  e;
          if (instr_id[d] != last_id[d]) age[d] = 0;
          else age[d]++;
          last_id[d] = instr_id[d];
          exp_r = !(mem_r[d] | mem_w[d]) || (age[d] == 2 * wait_of(d) + 3);
          chk(d, "ready", 32'(ready[d]), 32'(exp_r));
          if (prev_rdy[d]) begin
            if (exp_q[d].size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL dut%0d retire: got WB_EN_out=%0d, required no retire", d, wb_en_out[d]);
            end else begin
              e = exp_q[d].pop_front();
              chk(d, "WB_EN_out", 32'(wb_en_out[d]), 32'(e.wb));
              chk(d, "MEM_R_EN_out", 32'(mem_r_out[d]), 32'(e.mr));
              chk(d, "ALU_Res_out", alu_out[d], e.alu);
              chk(d, "Dest_out", 32'(dest_out[d]), 32'(e.dst));
              chk(d, "MEM_Result", mem_res[d], e.res);
            end
          end else begin
            chk(d, "WB_EN_out bubble", 32'(wb_en_out[d]), 32'd0);
          end
          prev_rdy[d] = ready[d];
        end
      end
    end
  end

  task automatic issue(input int d, input logic r, input logic w, input logic wb,
                       input logic [31:0] alu, input logic [31:0] rm, input logic [3:0] dst);
    wb_t         e;
    logic [16:0] idx;
    int          n;
    mem_r[d] = r; mem_w[d] = w; wb_en[d] = wb;
    alu_res[d] = alu; val_rm[d] = rm; dest[d] = dst;
    instr_id[d]++;
    idx = 17'((alu - BASE) >> 2);
    if (w) wmem[d * (1 << 17) + int'(idx)] = rm;
    else if (r) rd_m[d] = ref_rd(d, idx);
    if (r | w) memres_m[d] = rd_m[d];
    e.wb = wb; e.mr = r; e.alu = alu; e.dst = dst; e.res = memres_m[d];
    exp_q[d].push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        $display("FAIL dut%0d ready timeout: got ready=0 after %0d cycles, required 1", d, n);
        $fatal(1, "ready never returned");
      end
    end while (ready[d] !== 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op(input int d);
    int          t;
    logic [31:0] a;
    logic [3:0]  dst;
    t   = int'($urandom_range(0, 9));
    dst = 4'($urandom_range(0, 15));
    a   = BASE + 32'($urandom_range(0, 31)) * 32'd4 + 32'($urandom_range(0, 3));
    if (t < 4)      issue(d, 1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, dst);
    else if (t < 7) issue(d, 1'b1, 1'b0, 1'b1, a, $urandom, dst);
    else if (t < 9) issue(d, 1'(t == 8), 1'b1, 1'b0, a, $urandom, dst);
    else begin
      a = BASE - 32'($urandom_range(1, 4)) * 32'd4;
      issue(d, 1'b1, 1'($urandom_range(0, 1)), 1'b1, a, $urandom, dst);
    end
  endtask

  task automatic set_nop(input int d);
    mem_r[d] = 1'b0; mem_w[d] = 1'b0; wb_en[d] = 1'b0;
    alu_res[d] = 32'd0; val_rm[d] = 32'd0; dest[d] = 4'd0;
  endtask

  task automatic chk_reset_state(input int d, input string tag);
    chk(d, {tag, " ready"}, 32'(ready[d]), 32'd1);
    chk(d, {tag, " WB_EN_out"}, 32'(wb_en_out[d]), 32'd0);
    chk(d, {tag, " MEM_R_EN_out"}, 32'(mem_r_out[d]), 32'd0);
    chk(d, {tag, " ALU_Res_out"}, alu_out[d], 32'd0);
    chk(d, {tag, " MEM_Result"}, mem_res[d], 32'd0);
    chk(d, {tag, " Dest_out"}, 32'(dest_out[d]), 32'd0);
    chk(d, {tag, " SRAM_WE_N"}, 32'(we_n[d]), 32'd1);
    chk(d, {tag, " SRAM_DQ_oe"}, 32'(oe[d]), 32'd0);
    chk(d, {tag, " SRAM_ADDR"}, 32'(s_addr[d]), 32'd0);
  endtask

  task automatic drain(input int d);
    issue(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    #1;
    rst_n[d] = 1'b0;
  endtask

  initial begin
    int wl;
    rst_n = 2'b00;
    set_nop(0);
    set_nop(1);
    for (int d = 0; d < 2; d++) begin instr_id[d] = 0; rd_m[d] = 32'd0; memres_m[d] = 32'd0; end
    repeat (3) @(posedge clk);
    #1;

    // WAIT=1 instance
    chk_reset_state(0, "reset");
    rst_n[0] = 1'b1;
    issue(0, 1'b0, 1'b0, 1'b1, 32'h55, 32'd0, 4'd3);
    wl = we_low[0];
    issue(0, 1'b0, 1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 4'd0);
    chk(0, "store WE_N low cycles", 32'(we_low[0] - wl), 32'(2 * W0));
    chk(0, "sram[4]", 32'(sram_rd(0, 18'd4)), 32'h0000BEEF);
    chk(0, "sram[5]", 32'(sram_rd(0, 18'd5)), 32'h0000DEAD);
    issue(0, 1'b1, 1'b0, 1'b1, 32'd1032, 32'd0, 4'd5);
    issue(0, 1'b1, 1'b0, 1'b1, 32'd1024, 32'd0, 4'd1);
    issue(0, 1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 4'd2);
    issue(0, 1'b0, 1'b1, 1'b0, BASE - 32'd4, 32'hCAFEF00D, 4'd0);
    chk(0, "wrap sram lo", 32'(sram_rd(0, 18'h3FFFE)), 32'h0000F00D);
    chk(0, "wrap sram hi", 32'(sram_rd(0, 18'h3FFFF)), 32'h0000CAFE);
    issue(0, 1'b1, 1'b0, 1'b1, BASE - 32'd3, 32'd0, 4'd6);
    for (int i = 0; i < 150; i++) rand_op(0);

    // Store aborted by reset in its first HIGH cycle
    mem_r[0] = 1'b0; mem_w[0] = 1'b1; wb_en[0] = 1'b1;
    alu_res[0] = BASE + 32'd4000; val_rm[0] = $urandom; dest[0] = 4'd7;
    instr_id[0]++;
    repeat (W0 + 2) @(posedge clk);
    #1;
    chk(0, "HIGH SRAM_WE_N", 32'(we_n[0]), 32'd0);
    chk(0, "HIGH SRAM_ADDR", 32'(s_addr[0]), 32'd2001);
    rst_n[0] = 1'b0;
    set_nop(0);
    instr_id[0]++;
    #1;
    chk_reset_state(0, "abort");
    rd_m[0] = 32'd0;
    memres_m[0] = 32'd0;
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    for (int i = 0; i < 20; i++) rand_op(0);
    drain(0);

    // WAIT=3 instance
    @(posedge clk);
    #1;
    chk_reset_state(1, "reset");
    rst_n[1] = 1'b1;
    issue(1, 1'b1, 1'b0, 1'b1, 32'd1024, 32'd0, 4'd9);
    wl = we_low[1];
    issue(1, 1'b0, 1'b1, 1'b0, 32'd1040, 32'h12345678, 4'd0);
    chk(1, "store WE_N low cycles", 32'(we_low[1] - wl), 32'(2 * W1));
    issue(1, 1'b1, 1'b0, 1'b1, 32'd1040, 32'd0, 4'd4);
    for (int i = 0; i < 40; i++) rand_op(1);
    drain(1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
